hazard_mem_ctrl: RTL and testbench
==================================

Name: hazard_mem_ctrl

Overview:
- Central pipeline controller for the 5-stage RV32I core. It drives the stall, flush and forward selects for the IF/ID, ID/EX, EX/MEM and MEM/WB registers.
- It also sequences data-memory accesses held in the EX/MEM register with a req/ready handshake, so multi-cycle memory freezes the pipe correctly.
- It keeps a saturating stall-cycle counter and a sticky memory-timeout flag.

Parameters:
- MAX_WAIT, 15, consecutive WAIT cycles before the timeout flag sets.
- CNT_W, 16, width of the stall-cycle counter.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- Rs1D, Rs2D  in  5  source registers in Decode.
- Rs1E, Rs2E, RdE  in  5  source and destination registers in Execute.
- ResultSrcE  in  2  Execute result select; 2'b01 = load.
- PCSrcE  in  1  taken branch/jump resolved in Execute.
- RdM  in  5  Memory-stage destination register.
- RegWriteM, MemWriteM  in  1  Memory-stage controls.
- ResultSrcM  in  2  Memory-stage result select; 2'b01 = load.
- RdW  in  5  Writeback destination register.
- RegWriteW  in  1  Writeback write enable.
- DMemReady  in  1  data memory completes the access this cycle.
- DMemReq  out  1  data-memory access request.
- StallF, StallD, StallE, StallM  out  1  hold the PC, IF/ID, ID/EX and EX/MEM registers.
- FlushD, FlushE, FlushW  out  1  clear IF/ID, ID/EX and MEM/WB to a bubble.
- ForwardAE, ForwardBE  out  2  ALU operand select: 00 = register file, 01 = Writeback result, 10 = ALUResultM.
- StallCount  out  CNT_W  total stalled cycles, saturating.
- MemTimeout  out  1  sticky error flag.

Behaviour:
- Reset, asynchronous, active-high:
  - state = IDLE, StallCount = 0, wait counter = 0, MemTimeout = 0.
  - While rst is high, every combinational output is forced to 0.
- Memory-stage access: memM = MemWriteM | (ResultSrcM == 2'b01).
- FSM states IDLE and WAIT, registered on posedge clk:
  - IDLE: DMemReq = memM.
    - memM & DMemReady: single-cycle access; no memory stall; stay IDLE.
    - memM & !DMemReady: memStall = 1 this cycle; next state WAIT.
  - WAIT: DMemReq = 1.
    - !DMemReady: memStall = 1; stay WAIT.
    - DMemReady: memStall = 0; the pipe advances at this edge; next state IDLE.
- Under memStall: StallF = StallD = StallE = StallM = 1, FlushW = 1, FlushD = FlushE = 0.
  - memStall has absolute priority: a branch or load-use condition present during the stall is evaluated again after release.
- Load-use, only when memStall = 0:
  - lwStall = (ResultSrcE == 2'b01) & (RdE != 0) & ((RdE == Rs1D) | (RdE == Rs2D)).
  - lwStall gives StallF = StallD = 1 and FlushE = 1.
- Branch, only when memStall = 0: PCSrcE gives FlushD = 1 and FlushE = 1.
  - Branch and lwStall together: FlushE = 1, FlushD = 1, StallF = StallD = 1. The stall is harmless because IF/ID is flushed.
- Forwarding (shown for A; B is identical using Rs2E):
  - 10 if RegWriteM & (RdM != 0) & (RdM == Rs1E);
  - else 01 if RegWriteW & (RdW != 0) & (RdW == Rs1E);
  - else 00.
  - Memory takes precedence over Writeback. Forwarding is computed regardless of stalls.
- StallCount increments on every edge where StallF = 1 (memStall or lwStall). It saturates at all-ones.
- Wait counter:
  - Cleared in IDLE; increments each cycle in WAIT; saturates.
  - When the counter reaches MAX_WAIT while still in WAIT, MemTimeout is set. It is cleared only by rst.
  - The FSM keeps waiting after timeout; there is no abort.
- rst asserted mid-WAIT: DMemReq drops to 0 immediately, asynchronously, and the state returns to IDLE.

Test Plan:
1. Forward priority: RdM = RdW = Rs1E = 5, RegWriteM = RegWriteW = 1 -> ForwardAE = 10. With RdM = 0 -> ForwardAE = 01. With RdW = Rs1E = 0, RegWriteW = 1 -> ForwardAE = 00.
2. Load-use: ResultSrcE = 01, RdE = 3, Rs2D = 3 -> StallF = StallD = FlushE = 1 for exactly 1 cycle, StallCount increments by 1. Same case with RdE = 0 -> no stall.
3. Branch flush: PCSrcE = 1, no memory op -> FlushD = FlushE = 1, no stalls, StallCount unchanged.
4. Multi-cycle load: ResultSrcM = 01, DMemReady low 3 cycles then high -> DMemReq high 4 cycles; StallF/D/E/M and FlushW high 3 cycles; FSM returns to IDLE; StallCount = 3. A PCSrcE pulse during those cycles gives FlushD = FlushE = 0.
5. Timeout: MAX_WAIT = 15, DMemReady held low 20 cycles -> MemTimeout rises after 15 WAIT cycles and stays high after DMemReady. A later rst clears it.
6. Reset mid-WAIT: assert rst asynchronously while in WAIT -> DMemReq and all stalls go to 0 in the same cycle, StallCount = 0. After release, a store with DMemReady = 1 completes in 1 cycle with no stall.

Source files
------------

// File: rtl/hazard_mem_ctrl_if.sv
// -----------------------------------------------------------------------------
// hazard_mem_ctrl_if
//   Bundle of the pipeline-control signals shared between the RV32I datapath
//   and the hazard / data-memory controller.
//
//   master : pipeline side. It drives the register indices, stage controls and
//            DMemReady, and receives the stall/flush/forward controls.
//   slave  : hazard_mem_ctrl. It receives the pipeline state and drives
//            DMemReq, the stall/flush/forward controls, StallCount and
//            MemTimeout.
//
//   Parameter CNT_W is the width of StallCount.
// -----------------------------------------------------------------------------
interface hazard_mem_ctrl_if #(
  parameter int CNT_W = 16
);
  // Decode
  logic [4:0]       Rs1D, Rs2D;
  // Execute
  logic [4:0]       Rs1E, Rs2E, RdE;
  logic [1:0]       ResultSrcE;
  logic             PCSrcE;
  // Memory
  logic [4:0]       RdM;
  logic             RegWriteM, MemWriteM;
  logic [1:0]       ResultSrcM;
  // Writeback
  logic [4:0]       RdW;
  logic             RegWriteW;
  // Data-memory handshake
  logic             DMemReq, DMemReady;
  // Pipeline controls
  logic             StallF, StallD, StallE, StallM;
  logic             FlushD, FlushE, FlushW;
  logic [1:0]       ForwardAE, ForwardBE;
  // Status
  logic [CNT_W-1:0] StallCount;
  logic             MemTimeout;

  modport master (
    output Rs1D, Rs2D, Rs1E, Rs2E, RdE, ResultSrcE, PCSrcE,
           RdM, RegWriteM, MemWriteM, ResultSrcM, RdW, RegWriteW, DMemReady,
    input  DMemReq, StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW,
           ForwardAE, ForwardBE, StallCount, MemTimeout
  );

  modport slave (
    input  Rs1D, Rs2D, Rs1E, Rs2E, RdE, ResultSrcE, PCSrcE,
           RdM, RegWriteM, MemWriteM, ResultSrcM, RdW, RegWriteW, DMemReady,
    output DMemReq, StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW,
           ForwardAE, ForwardBE, StallCount, MemTimeout
  );
endinterface

// File: rtl/hazard_mem_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_mem_ctrl
//   Central hazard unit for the 5-stage RV32I pipeline.
//   - Operand forwarding from EX/MEM and MEM/WB into Execute.
//   - Load-use stall and taken-branch flush.
//   - Sequencing of the data-memory access held in EX/MEM with a req/ready
//     handshake. A multi-cycle access freezes PC, IF/ID, ID/EX and EX/MEM and
//     bubbles MEM/WB until the memory answers.
//   - Saturating count of stalled cycles and a sticky memory-timeout flag.
//
// Ports
//   clk  : clock
//   rst  : asynchronous active-high reset; all combinational outputs read 0
//          while it is high
//   bus  : hazard_mem_ctrl_if.slave (pipeline state in, controls out)
//
// Parameters
//   MAX_WAIT : consecutive waiting cycles before MemTimeout sets (>= 1)
//   CNT_W    : StallCount width; must match the interface CNT_W
// -----------------------------------------------------------------------------
module hazard_mem_ctrl #(
  parameter int MAX_WAIT = 15,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  hazard_mem_ctrl_if.slave bus
);

  localparam int WAIT_W = $clog2(MAX_WAIT + 1);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_t;

  state_t            r_state, w_next_state;
  logic [WAIT_W-1:0] r_wait_cnt;
  logic [CNT_W-1:0]  r_stall_count;
  logic              r_mem_timeout;

  logic       w_mem_m, w_lw_stall, w_mem_stall;
  logic       w_dmem_req;
  logic       w_stall_f, w_stall_d, w_stall_e, w_stall_m;
  logic       w_flush_d, w_flush_e, w_flush_w;
  logic [1:0] w_fwd_a, w_fwd_b;

  // Memory stage forwarding wins over Writeback: it holds the younger value.
  function automatic logic [1:0] fwd_sel(input logic [4:0] rs,
                                         input logic       reg_write_m,
                                         input logic [4:0] rd_m,
                                         input logic       reg_write_w,
                                         input logic [4:0] rd_w);
    if (reg_write_m && (rd_m != 5'd0) && (rd_m == rs))      return 2'b10;
    else if (reg_write_w && (rd_w != 5'd0) && (rd_w == rs)) return 2'b01;
    else                                                     return 2'b00;
  endfunction

  assign w_mem_m    = bus.MemWriteM || (bus.ResultSrcM == 2'b01);
  assign w_lw_stall = (bus.ResultSrcE == 2'b01) && (bus.RdE != 5'd0) &&
                      ((bus.RdE == bus.Rs1D) || (bus.RdE == bus.Rs2D));

  // NOTE: every signal written here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    w_next_state = r_state;
    w_mem_stall  = 1'b0;
    w_dmem_req   = 1'b0;
    w_stall_f    = 1'b0;
    w_stall_d    = 1'b0;
    w_stall_e    = 1'b0;
    w_stall_m    = 1'b0;
    w_flush_d    = 1'b0;
    w_flush_e    = 1'b0;
    w_flush_w    = 1'b0;
    w_fwd_a      = 2'b00;
    w_fwd_b      = 2'b00;

    case (r_state)
      S_IDLE: begin
        w_dmem_req = w_mem_m;
        if (w_mem_m && !bus.DMemReady) begin
          w_mem_stall  = 1'b1;
          w_next_state = S_WAIT;
        end
      end
      S_WAIT: begin
        w_dmem_req = 1'b1;
        if (!bus.DMemReady) w_mem_stall  = 1'b1;
        else                w_next_state = S_IDLE;
      end
      default: w_next_state = S_IDLE;
    endcase

    // A memory freeze overrides everything; branch and load-use are simply
    // re-evaluated once the pipe moves again.
    if (w_mem_stall) begin
      w_stall_f = 1'b1;
      w_stall_d = 1'b1;
      w_stall_e = 1'b1;
      w_stall_m = 1'b1;
      w_flush_w = 1'b1;
    end else begin
      w_stall_f = w_lw_stall;
      w_stall_d = w_lw_stall;
      w_flush_d = bus.PCSrcE;
      w_flush_e = bus.PCSrcE || w_lw_stall;
    end

    w_fwd_a = fwd_sel(bus.Rs1E, bus.RegWriteM, bus.RdM, bus.RegWriteW, bus.RdW);
    w_fwd_b = fwd_sel(bus.Rs2E, bus.RegWriteM, bus.RdM, bus.RegWriteW, bus.RdW);

    // Reset gates the outputs directly so DMemReq drops without waiting for
    // the state register.
    if (rst) begin
      w_dmem_req = 1'b0;
      w_stall_f  = 1'b0;
      w_stall_d  = 1'b0;
      w_stall_e  = 1'b0;
      w_stall_m  = 1'b0;
      w_flush_d  = 1'b0;
      w_flush_e  = 1'b0;
      w_flush_w  = 1'b0;
      w_fwd_a    = 2'b00;
      w_fwd_b    = 2'b00;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next_state;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall_count <= '0;
      r_wait_cnt    <= '0;
      r_mem_timeout <= 1'b0;
    end else begin
      if (w_stall_f && (r_stall_count != '1))
        r_stall_count <= r_stall_count + CNT_W'(1);

      // Counts consecutive unanswered WAIT cycles; the flag sets on the edge
      // that completes the MAX_WAIT-th one and stays until reset.
      if ((r_state == S_WAIT) && !bus.DMemReady) begin
        if (r_wait_cnt != WAIT_W'(MAX_WAIT))
          r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
        if (r_wait_cnt == WAIT_W'(MAX_WAIT - 1))
          r_mem_timeout <= 1'b1;
      end else begin
        r_wait_cnt <= '0;
      end
    end
  end

  assign bus.DMemReq    = w_dmem_req;
  assign bus.StallF     = w_stall_f;
  assign bus.StallD     = w_stall_d;
  assign bus.StallE     = w_stall_e;
  assign bus.StallM     = w_stall_m;
  assign bus.FlushD     = w_flush_d;
  assign bus.FlushE     = w_flush_e;
  assign bus.FlushW     = w_flush_w;
  assign bus.ForwardAE  = w_fwd_a;
  assign bus.ForwardBE  = w_fwd_b;
  assign bus.StallCount = r_stall_count;
  assign bus.MemTimeout = r_mem_timeout;

endmodule

// File: tb/tb_hazard_mem_ctrl.sv
// -----------------------------------------------------------------------------
// tb_hazard_mem_ctrl
//   Directed scenarios followed by random traffic. Expected values come from a
//   reference model that tracks only whether a memory access is outstanding,
//   how long it has gone unanswered, the stall total and the timeout flag.
// -----------------------------------------------------------------------------
module tb_hazard_mem_ctrl;

  localparam int MAX_WAIT = 15;
  localparam int CNT_W    = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  hazard_mem_ctrl_if #(.CNT_W(CNT_W)) bus ();

  hazard_mem_ctrl #(.MAX_WAIT(MAX_WAIT), .CNT_W(CNT_W)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    logic       req, sf, sd, se, sm, fd, fe, fw;
    logic [1:0] fa, fb;
  } exp_t;

  bit m_pending;     // an access stalled last cycle and is still outstanding
  int m_waits;       // unanswered cycles of that outstanding access
  bit m_timeout;
  int m_stall_count;

  function automatic logic [1:0] ref_fwd(input logic [4:0] rs);
    if (bus.RegWriteM && bus.RdM != 0 && bus.RdM == rs) return 2'b10;
    if (bus.RegWriteW && bus.RdW != 0 && bus.RdW == rs) return 2'b01;
    return 2'b00;
  endfunction

  function automatic exp_t model_comb();
    exp_t e;
    logic access, mem_stall, lw;
    access    = bus.MemWriteM || (bus.ResultSrcM == 2'b01);
    mem_stall = (m_pending || access) && !bus.DMemReady;
    lw        = (bus.ResultSrcE == 2'b01) && (bus.RdE != 0) &&
                ((bus.RdE == bus.Rs1D) || (bus.RdE == bus.Rs2D));
    e.req = m_pending || access;
    e.sf  = mem_stall || lw;
    e.sd  = mem_stall || lw;
    e.se  = mem_stall;
    e.sm  = mem_stall;
    e.fw  = mem_stall;
    e.fd  = !mem_stall && bus.PCSrcE;
    e.fe  = !mem_stall && (bus.PCSrcE || lw);
    e.fa  = ref_fwd(bus.Rs1E);
    e.fb  = ref_fwd(bus.Rs2E);
    return e;
  endfunction

  exp_t cur;

  task automatic model_reset();
    m_pending     = 1'b0;
    m_waits       = 0;
    m_timeout     = 1'b0;
    m_stall_count = 0;
  endtask

  task automatic clear_inputs();
    bus.Rs1D = 0; bus.Rs2D = 0; bus.Rs1E = 0; bus.Rs2E = 0; bus.RdE = 0;
    bus.ResultSrcE = 0; bus.PCSrcE = 0; bus.RdM = 0; bus.RegWriteM = 0;
    bus.MemWriteM = 0; bus.ResultSrcM = 0; bus.RdW = 0; bus.RegWriteW = 0;
    bus.DMemReady = 0;
  endtask

  // Called at posedge+1; compares every output against the model mid-cycle.
  task automatic eval(input string tag);
    #3;
    cur = model_comb();
    check({tag, "/DMemReq"},    32'(bus.DMemReq),    32'(cur.req));
    check({tag, "/StallF"},     32'(bus.StallF),     32'(cur.sf));
    check({tag, "/StallD"},     32'(bus.StallD),     32'(cur.sd));
    check({tag, "/StallE"},     32'(bus.StallE),     32'(cur.se));
    check({tag, "/StallM"},     32'(bus.StallM),     32'(cur.sm));
    check({tag, "/FlushD"},     32'(bus.FlushD),     32'(cur.fd));
    check({tag, "/FlushE"},     32'(bus.FlushE),     32'(cur.fe));
    check({tag, "/FlushW"},     32'(bus.FlushW),     32'(cur.fw));
    check({tag, "/ForwardAE"},  32'(bus.ForwardAE),  32'(cur.fa));
    check({tag, "/ForwardBE"},  32'(bus.ForwardBE),  32'(cur.fb));
    check({tag, "/StallCount"}, 32'(bus.StallCount), 32'(m_stall_count));
    check({tag, "/MemTimeout"}, 32'(bus.MemTimeout), 32'(m_timeout));
  endtask

  // Clock edge plus model update; returns at posedge+1.
  task automatic adv();
    @(posedge clk);
    if (cur.sf && m_stall_count < (1 << CNT_W) - 1) m_stall_count++;
    if (m_pending && !bus.DMemReady) begin
      m_waits++;
      if (m_waits >= MAX_WAIT) m_timeout = 1'b1;
    end else begin
      m_waits = 0;
    end
    m_pending = cur.se;
    #1;
  endtask

  // Asynchronous reset pulse starting mid-cycle; returns at posedge+1.
  task automatic reset_dut(input string tag);
    #1 rst = 1'b1;
    #1;
    check({tag, "/rst_DMemReq"},    32'(bus.DMemReq),    32'd0);
    check({tag, "/rst_StallF"},     32'(bus.StallF),     32'd0);
    check({tag, "/rst_StallM"},     32'(bus.StallM),     32'd0);
    check({tag, "/rst_StallCount"}, 32'(bus.StallCount), 32'd0);
    check({tag, "/rst_MemTimeout"}, 32'(bus.MemTimeout), 32'd0);
    model_reset();
    @(posedge clk);
    #1 rst = 1'b0;
    clear_inputs();
  endtask

  int base;

  initial begin
    // ---- reset state: outputs forced low even with active hazards ----
    rst = 1'b1;
    clear_inputs();
    bus.Rs1E = 5; bus.RdM = 5; bus.RegWriteM = 1; bus.ResultSrcM = 2'b01;
    bus.PCSrcE = 1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("reset/ForwardAE",  32'(bus.ForwardAE),  32'd0);
    check("reset/DMemReq",    32'(bus.DMemReq),    32'd0);
    check("reset/FlushD",     32'(bus.FlushD),     32'd0);
    check("reset/StallCount", 32'(bus.StallCount), 32'd0);
    check("reset/MemTimeout", 32'(bus.MemTimeout), 32'd0);
    rst = 1'b0;
    clear_inputs();

    // ---- 1. forwarding priority ----
    bus.RdM = 5; bus.RdW = 5; bus.Rs1E = 5; bus.Rs2E = 5;
    bus.RegWriteM = 1; bus.RegWriteW = 1;
    eval("fwd_mem");
    check("fwd_mem/A_is_10", 32'(bus.ForwardAE), 32'd2);
    check("fwd_mem/B_is_10", 32'(bus.ForwardBE), 32'd2);
    adv();
    bus.RdM = 0;
    eval("fwd_wb");
    check("fwd_wb/A_is_01", 32'(bus.ForwardAE), 32'd1);
    adv();
    bus.RdM = 7; bus.RdW = 0; bus.Rs1E = 0;
    eval("fwd_x0");
    check("fwd_x0/A_is_00", 32'(bus.ForwardAE), 32'd0);
    adv();
    clear_inputs();

    // ---- 2. load-use ----
    base = m_stall_count;
    bus.ResultSrcE = 2'b01; bus.RdE = 3; bus.Rs2D = 3; bus.Rs1D = 9;
    eval("lw");
    check("lw/StallF", 32'(bus.StallF), 32'd1);
    check("lw/FlushE", 32'(bus.FlushE), 32'd1);
    check("lw/StallE", 32'(bus.StallE), 32'd0);
    adv();
    clear_inputs();
    eval("lw_after");
    check("lw_after/StallF",     32'(bus.StallF),     32'd0);
    check("lw_after/StallCount", 32'(bus.StallCount), 32'(base + 1));
    adv();
    bus.ResultSrcE = 2'b01; bus.RdE = 0; bus.Rs1D = 0;
    eval("lw_x0");
    check("lw_x0/StallF", 32'(bus.StallF), 32'd0);
    adv();
    clear_inputs();

    // ---- 3. branch flush ----
    base = m_stall_count;
    bus.PCSrcE = 1;
    eval("br");
    check("br/FlushD", 32'(bus.FlushD), 32'd1);
    check("br/FlushE", 32'(bus.FlushE), 32'd1);
    check("br/StallF", 32'(bus.StallF), 32'd0);
    adv();
    clear_inputs();
    eval("br_after");
    check("br_after/StallCount", 32'(bus.StallCount), 32'(base));
    adv();

    // ---- 4. multi-cycle load ----
    reset_dut("pre_load");
    bus.ResultSrcM = 2'b01; bus.DMemReady = 0;
    for (int i = 0; i < 3; i++) begin
      bus.PCSrcE = (i == 1);
      eval($sformatf("load_wait%0d", i));
      check($sformatf("load_wait%0d/DMemReq", i), 32'(bus.DMemReq), 32'd1);
      check($sformatf("load_wait%0d/StallM", i),  32'(bus.StallM),  32'd1);
      check($sformatf("load_wait%0d/FlushW", i),  32'(bus.FlushW),  32'd1);
      check($sformatf("load_wait%0d/FlushD", i),  32'(bus.FlushD),  32'd0);
      adv();
    end
    bus.PCSrcE = 0; bus.DMemReady = 1;
    eval("load_done");
    check("load_done/DMemReq", 32'(bus.DMemReq), 32'd1);
    check("load_done/StallF",  32'(bus.StallF),  32'd0);
    adv();
    clear_inputs();
    eval("load_idle");
    check("load_idle/DMemReq",    32'(bus.DMemReq),    32'd0);
    check("load_idle/StallCount", 32'(bus.StallCount), 32'd3);
    adv();

    // ---- 5. timeout ----
    reset_dut("pre_tmo");
    bus.ResultSrcM = 2'b01; bus.DMemReady = 0;
    for (int i = 0; i < 20; i++) begin
      eval($sformatf("tmo%0d", i));
      if (i == 15) check("tmo/not_yet", 32'(bus.MemTimeout), 32'd0);
      if (i == 16) check("tmo/set",     32'(bus.MemTimeout), 32'd1);
      adv();
    end
    bus.DMemReady = 1;
    eval("tmo_release");
    adv();
    clear_inputs();
    eval("tmo_sticky");
    check("tmo_sticky/MemTimeout", 32'(bus.MemTimeout), 32'd1);
    adv();
    reset_dut("tmo_clear");

    // ---- 6. reset mid-WAIT, then single-cycle store ----
    bus.ResultSrcM = 2'b01; bus.DMemReady = 0;
    eval("rw_first");
    adv();
    eval("rw_wait");
    check("rw_wait/DMemReq", 32'(bus.DMemReq), 32'd1);
    reset_dut("rw_reset");
    bus.MemWriteM = 1; bus.DMemReady = 1;
    eval("store");
    check("store/DMemReq", 32'(bus.DMemReq), 32'd1);
    check("store/StallF",  32'(bus.StallF),  32'd0);
    adv();
    clear_inputs();
    eval("store_after");
    check("store_after/StallCount", 32'(bus.StallCount), 32'd0);
    adv();

    // ---- random traffic ----
    for (int n = 0; n < 400; n++) begin
      bus.Rs1D       = 5'($urandom_range(0, 3));
      bus.Rs2D       = 5'($urandom_range(0, 3));
      bus.Rs1E       = 5'($urandom_range(0, 3));
      bus.Rs2E       = 5'($urandom_range(0, 3));
      bus.RdE        = 5'($urandom_range(0, 3));
      bus.ResultSrcE = 2'($urandom_range(0, 3));
      bus.PCSrcE     = ($urandom_range(0, 4) == 0);
      bus.RdM        = 5'($urandom_range(0, 3));
      bus.RegWriteM  = 1'($urandom_range(0, 1));
      bus.MemWriteM  = ($urandom_range(0, 5) == 0);
      bus.ResultSrcM = 2'($urandom_range(0, 3));
      bus.RdW        = 5'($urandom_range(0, 3));
      bus.RegWriteW  = 1'($urandom_range(0, 1));
      bus.DMemReady  = ($urandom_range(0, 3) != 0);
      eval($sformatf("rand%0d", n));
      adv();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
